// File: rtl/mult_share_arbiter.sv
// Round-robin shared pipelined multiplier.
// NUM_REQ clients, one grant per cycle, in-order tagged responses.
module mult_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2,
  parameter int A0_WIDTH = 8,
  parameter int A1_WIDTH = 8,
  parameter int LATENCY  = 3,
  localparam int PRODUCT_WIDTH = A0_WIDTH + A1_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*A0_WIDTH-1:0]   a0_bus,
  input  logic [NUM_REQ*A1_WIDTH-1:0]   a1_bus,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [PRODUCT_WIDTH-1:0]      product
);

  logic [ID_WIDTH-1:0]      ptr_q;
  logic [ID_WIDTH-1:0]      ptr_d;
  logic [ID_WIDTH-1:0]      sel;
  logic                     hit;
  logic                     take;
  logic                     stall;
  logic [A0_WIDTH-1:0]      a0_sel;
  logic [A1_WIDTH-1:0]      a1_sel;
  logic [PRODUCT_WIDTH-1:0] prod_d;
  int                       idx;

  logic [LATENCY-1:0]       vld_q;
  logic [ID_WIDTH-1:0]      id_q   [LATENCY];
  logic [PRODUCT_WIDTH-1:0] prod_q [LATENCY];

  assign stall = vld_q[LATENCY-1] & ~rsp_ready;

  // Rotating search from the pointer, operand mux and next pointer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!hit && req[idx]) begin
        hit = 1'b1;
        sel = ID_WIDTH'(idx);
      end
    end
    take = hit & ~stall & ~reset;
    gnt  = '0;
    if (take) gnt[sel] = 1'b1;
    a0_sel = a0_bus[int'(sel)*A0_WIDTH +: A0_WIDTH];
    a1_sel = a1_bus[int'(sel)*A1_WIDTH +: A1_WIDTH];
    // Operands are widened first so the product is never truncated.
    prod_d = PRODUCT_WIDTH'(a0_sel) * PRODUCT_WIDTH'(a1_sel);
    ptr_d  = ptr_q;
    if (take) begin
      if (int'(sel) == NUM_REQ - 1) ptr_d = '0;
      else ptr_d = sel + 1'b1;
    end
  end

  // Pointer and product pipeline; everything freezes on stall.
  // The product is formed ahead of stage 1 so LATENCY=1 still works.
  // Data only moves with a valid entry, so bubbles leave the
  // output product/id holding their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i]   <= '0;
        prod_q[i] <= '0;
      end
    end else if (!stall) begin
      ptr_q    <= ptr_d;
      vld_q[0] <= take;
      if (take) begin
        id_q[0]   <= sel;
        prod_q[0] <= prod_d;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          id_q[i]   <= id_q[i-1];
          prod_q[i] <= prod_q[i-1];
        end
      end
    end
  end

  assign rsp_valid = vld_q[LATENCY-1];
  assign rsp_id    = id_q[LATENCY-1];
  assign product   = prod_q[LATENCY-1];

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter.
// Directed vectors push expectations; a negedge monitor retires them.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] a0_bus;
  logic [31:0] a1_bus;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] product;

  logic [7:0] op0 [4];
  logic [7:0] op1 [4];
  int         ep  [4];

  typedef struct {
    int id;
    int prod;
    int ecyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   timed = 1'b1;

  assign a0_bus = {op0[3], op0[2], op0[1], op0[0]};
  assign a1_bus = {op1[3], op1[2], op1[1], op1[0]};

  mult_share_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a0_bus    (a0_bus),
    .a1_bus    (a1_bus),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .product   (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b,
                         input int p);
    op0[i] = 8'(a);
    op1[i] = 8'(b);
    ep[i]  = p;
  endtask

  // Drive one cycle of requests, check grant, record expected response.
  task automatic step(input logic [3:0] r, input logic [3:0] eg,
                      input bit push);
    req = r;
    #1;
    chk("gnt", int'(gnt), int'(eg));
    if (push && eg != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (eg[k]) sb.push_back('{id: k, prod: ep[k],
                                  ecyc: timed ? cyc + 3 : -1});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted response must match the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rsp: got id=%0d product=%0d, required none",
                 rsp_id, product);
      end else begin
        e = sb.pop_front();
        if (int'(rsp_id) != e.id || int'(product) != e.prod) begin
          fails++;
          $display("FAIL rsp: got id=%0d product=%0d, required id=%0d product=%0d",
                   rsp_id, product, e.id, e.prod);
        end
        if (e.ecyc >= 0) chk("rsp_latency_cycle", cyc, e.ecyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req       = 4'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 0, 0, 0);

    // Reset state, gnt masked while reset is high
    repeat (2) @(posedge clk);
    #1;
    req = 4'b1111;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(rsp_valid), 0);
    chk("rst_id", int'(rsp_id), 0);
    chk("rst_product", int'(product), 0);
    req   = 4'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single request, 3-cycle latency
    set_ops(2, 12, 11, 132);
    step(4'b0100, 4'b0100, 1);
    chk("t1_valid_c1", int'(rsp_valid), 0);
    step(4'b0000, 4'b0000, 1);
    chk("t1_valid_c2", int'(rsp_valid), 0);
    step(4'b0000, 4'b0000, 1);
    chk("t1_valid_c3", int'(rsp_valid), 1);
    chk("t1_id", int'(rsp_id), 2);
    chk("t1_product", int'(product), 132);
    repeat (2) step(4'b0000, 4'b0000, 1);

    // Fresh pointer, then all four requesting
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    timed = 1'b0;
    set_ops(0, 3, 5, 15);
    set_ops(1, 10, 20, 200);
    set_ops(2, 100, 7, 700);
    set_ops(3, 255, 255, 65025);
    step(4'b1111, 4'b0001, 1);
    step(4'b1111, 4'b0010, 1);
    step(4'b1111, 4'b0100, 1);
    step(4'b1111, 4'b1000, 1);
    step(4'b1111, 4'b0001, 1);

    // Backpressure: requester 2's product sits at the output
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_id", int'(rsp_id), 2);
      chk("bp_product", int'(product), 700);
      step(4'b1111, 4'b0000, 1);
    end
    rsp_ready = 1'b1;
    step(4'b1111, 4'b0010, 1);
    step(4'b1111, 4'b0100, 1);
    repeat (8) step(4'b0000, 4'b0000, 1);
    timed = 1'b1;

    // Priority wrap
    step(4'b1000, 4'b1000, 1);
    step(4'b1001, 4'b0001, 1);
    step(4'b1001, 4'b1000, 1);
    repeat (6) step(4'b0000, 4'b0000, 1);

    // Reset with three products in flight
    step(4'b1111, 4'b0001, 0);
    step(4'b1111, 4'b0010, 0);
    step(4'b1111, 4'b0100, 0);
    req   = 4'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_id", int'(rsp_id), 0);
    chk("mid_rst_product", int'(product), 0);
    chk("mid_rst_gnt", int'(gnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_valid", int'(rsp_valid), 0);
      step(4'b0000, 4'b0000, 1);
    end
    step(4'b1010, 4'b0010, 1);
    repeat (4) step(4'b0000, 4'b0000, 1);

    // Sparse traffic, two cycles apart
    step(4'b0001, 4'b0001, 1);
    chk("sp_c1", int'(rsp_valid), 0);
    step(4'b0000, 4'b0000, 1);
    chk("sp_c2", int'(rsp_valid), 0);
    step(4'b0100, 4'b0100, 1);
    chk("sp_c3", int'(rsp_valid), 1);
    step(4'b0000, 4'b0000, 1);
    chk("sp_c4", int'(rsp_valid), 0);
    step(4'b1000, 4'b1000, 1);
    chk("sp_c5", int'(rsp_valid), 1);
    step(4'b0000, 4'b0000, 1);
    chk("sp_c6", int'(rsp_valid), 0);
    step(4'b0000, 4'b0000, 1);
    chk("sp_c7", int'(rsp_valid), 1);
    step(4'b0000, 4'b0000, 1);
    chk("sp_c8", int'(rsp_valid), 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
